// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with registered
// sync, display-enable, coordinate and per-frame strobe outputs.
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE  = 800,
   parameter int unsigned H_FRONT    = 56,
   parameter int unsigned H_SYNC     = 120,
   parameter int unsigned H_BACK     = 64,
   parameter int unsigned V_VISIBLE  = 600,
   parameter int unsigned V_FRONT    = 37,
   parameter int unsigned V_SYNC     = 6,
   parameter int unsigned V_BACK     = 23,
   parameter bit          H_SYNC_POL = 1'b1,
   parameter bit          V_SYNC_POL = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_disp_enbl,
   output logic [10:0] o_h_coord,
   output logic [9:0]  o_v_coord,
   output logic        o_frame_start,
   output logic        o_frame_end
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL > 2048 || H_TOTAL == 0) begin : gen_h_total_check
      $error("vga_timing_gen: H_TOTAL must be in 1..2048");
   end
   if (V_TOTAL > 1024 || V_TOTAL == 0) begin : gen_v_total_check
      $error("vga_timing_gen: V_TOTAL must be in 1..1024");
   end

   // Compare in one extra bit so a visible width equal to the full range still decodes.
   localparam logic [11:0] H_VIS        = 12'(H_VISIBLE);
   localparam logic [11:0] H_SYNC_START = 12'(H_VISIBLE + H_FRONT);
   localparam logic [11:0] H_SYNC_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_VIS        = 11'(V_VISIBLE);
   localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);

   // Next pixel to present; the output registers lag it by exactly one cycle.
   logic [10:0] h_q, h_d;
   logic [9:0]  v_q, v_d;
   logic [11:0] h_ext;
   logic [10:0] v_ext;
   logic        disp_d, hsync_d, vsync_d, fstart_d, fend_d;

   always_comb begin
      h_d = h_q + 11'd1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end
   end

   always_comb begin
      h_ext    = {1'b0, h_q};
      v_ext    = {1'b0, v_q};
      disp_d   = (h_ext < H_VIS) && (v_ext < V_VIS);
      hsync_d  = ((h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END)) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_d  = ((v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END)) ? V_SYNC_POL : ~V_SYNC_POL;
      fstart_d = (h_q == '0) && (v_q == '0);
      fend_d   = (h_q == '0) && (v_ext == V_VIS);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         h_q           <= '0;
         v_q           <= '0;
         o_h_coord     <= '0;
         o_v_coord     <= '0;
         o_disp_enbl   <= 1'b0;
         o_hsync       <= ~H_SYNC_POL;
         o_vsync       <= ~V_SYNC_POL;
         o_frame_start <= 1'b0;
         o_frame_end   <= 1'b0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         o_h_coord     <= h_q;
         o_v_coord     <= v_q;
         o_disp_enbl   <= disp_d;
         o_hsync       <= hsync_d;
         o_vsync       <= vsync_d;
         o_frame_start <= fstart_d;
         o_frame_end   <= fend_d;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: two small geometries (both sync polarities)
// checked every cycle against a pixel-index model, plus frame-level aggregates.
module tb_vga_timing_gen;

   typedef struct packed {
      int unsigned hv, hf, hs, hb, vv, vf, vs, vb;
      bit          hp, vp;
   } geom_t;

   localparam geom_t GA = '{hv: 40, hf: 4, hs: 6, hb: 5, vv: 20, vf: 3, vs: 2, vb: 4,
                            hp: 1'b1, vp: 1'b1};
   localparam geom_t GB = '{hv: 32, hf: 2, hs: 8, hb: 4, vv: 16, vf: 2, vs: 1, vb: 3,
                            hp: 1'b0, vp: 1'b0};

   logic        clk;
   logic        rst_n;
   logic        hs_a, vs_a, de_a, fs_a, fe_a;
   logic        hs_b, vs_b, de_b, fs_b, fe_b;
   logic [10:0] h_a, h_b;
   logic [9:0]  v_a, v_b;
   int unsigned edges;
   int          n_checks;
   int          n_fail;

   vga_timing_gen #(
      .H_VISIBLE(GA.hv), .H_FRONT(GA.hf), .H_SYNC(GA.hs), .H_BACK(GA.hb),
      .V_VISIBLE(GA.vv), .V_FRONT(GA.vf), .V_SYNC(GA.vs), .V_BACK(GA.vb),
      .H_SYNC_POL(GA.hp), .V_SYNC_POL(GA.vp)
   ) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .o_hsync(hs_a), .o_vsync(vs_a), .o_disp_enbl(de_a),
      .o_h_coord(h_a), .o_v_coord(v_a), .o_frame_start(fs_a), .o_frame_end(fe_a)
   );

   vga_timing_gen #(
      .H_VISIBLE(GB.hv), .H_FRONT(GB.hf), .H_SYNC(GB.hs), .H_BACK(GB.hb),
      .V_VISIBLE(GB.vv), .V_FRONT(GB.vf), .V_SYNC(GB.vs), .V_BACK(GB.vb),
      .H_SYNC_POL(GB.hp), .V_SYNC_POL(GB.vp)
   ) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .o_hsync(hs_b), .o_vsync(vs_b), .o_disp_enbl(de_b),
      .o_h_coord(h_b), .o_v_coord(v_b), .o_frame_start(fs_b), .o_frame_end(fe_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges seen since reset release; pixel index presented is edges-1.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges <= 0;
      else        edges <= edges + 1;
   end

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs(input string name, input geom_t g, input int unsigned n,
                                input logic hs, input logic vs, input logic de,
                                input logic [10:0] h, input logic [9:0] v,
                                input logic fs, input logic fe);
      int unsigned ht, vt, p, eh, ev;
      bit ehs, evs, ede, efs, efe;
      ht = g.hv + g.hf + g.hs + g.hb;
      vt = g.vv + g.vf + g.vs + g.vb;
      if (n == 0) begin
         eh = 0; ev = 0; ede = 0; efs = 0; efe = 0;
         ehs = !g.hp; evs = !g.vp;
      end else begin
         p   = (n - 1) % (ht * vt);
         eh  = p % ht;
         ev  = p / ht;
         ede = (eh < g.hv) && (ev < g.vv);
         ehs = (eh >= g.hv + g.hf && eh < g.hv + g.hf + g.hs) ? g.hp : !g.hp;
         evs = (ev >= g.vv + g.vf && ev < g.vv + g.vf + g.vs) ? g.vp : !g.vp;
         efs = (eh == 0) && (ev == 0);
         efe = (eh == 0) && (ev == g.vv);
      end
      check_eq({name, ".h_coord"}, longint'(h), longint'(eh));
      check_eq({name, ".v_coord"}, longint'(v), longint'(ev));
      check_eq({name, ".disp_enbl"}, longint'(de), longint'(ede));
      check_eq({name, ".hsync"}, longint'(hs), longint'(ehs));
      check_eq({name, ".vsync"}, longint'(vs), longint'(evs));
      check_eq({name, ".frame_start"}, longint'(fs), longint'(efs));
      check_eq({name, ".frame_end"}, longint'(fe), longint'(efe));
   endtask

   // Per-cycle model comparison plus frame-level aggregates on dut_a.
   initial begin
      int last_fs;
      int de_cnt;
      int ht_a;
      ht_a    = int'(GA.hv + GA.hf + GA.hs + GA.hb);
      last_fs = -1;
      de_cnt  = 0;
      forever begin
         @(negedge clk);
         check_outputs("a", GA, edges, hs_a, vs_a, de_a, h_a, v_a, fs_a, fe_a);
         check_outputs("b", GB, edges, hs_b, vs_b, de_b, h_b, v_b, fs_b, fe_b);
         if (edges == 0) begin
            last_fs = -1;
            de_cnt  = 0;
         end else begin
            if (fs_a) begin
               if (last_fs >= 0) begin
                  check_eq("a.frame_period", longint'(int'(edges) - last_fs),
                           longint'(ht_a * int'(GA.vv + GA.vf + GA.vs + GA.vb)));
                  check_eq("a.de_per_frame", longint'(de_cnt), longint'(GA.hv * GA.vv));
               end
               last_fs = int'(edges);
               de_cnt  = 0;
            end
            if (fe_a && last_fs >= 0)
               check_eq("a.start_to_end", longint'(int'(edges) - last_fs),
                        longint'(ht_a * int'(GA.vv)));
            if (de_a) de_cnt++;
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (3500) @(negedge clk);
      for (int s = 0; s < 10; s++) begin
         // Assert reset between edges and confirm outputs clear before the next edge.
         #($urandom_range(1, 3));
         rst_n = 1'b0;
         #1;
         check_outputs("a_async_rst", GA, edges, hs_a, vs_a, de_a, h_a, v_a, fs_a, fe_a);
         check_outputs("b_async_rst", GB, edges, hs_b, vs_b, de_b, h_b, v_b, fs_b, fe_b);
         @(negedge clk);
         repeat ($urandom_range(0, 4)) @(negedge clk);
         rst_n = 1'b1;
         repeat ($urandom_range(50, 3000)) @(negedge clk);
      end
      repeat (1700) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
